// File: rtl/demux_1x4_sched.sv
// Scheduler and handshake controller for a 1x4 demultiplexer.
// Accepts one word at a time from a single producer and routes it to one of
// four consumers. Routing is round-robin over enabled channels or directed
// by the word's destination field. Directed words that target a disabled
// channel are dropped and counted.
module demux_1x4_sched #(
  parameter int DW = 8,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mode,
  input  logic [3:0]    chan_en,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic [1:0]    in_dest,
  output logic [3:0]    out_valid,
  input  logic [3:0]    out_ready,
  output logic [DW-1:0] out_data,
  output logic [1:0]    sel,
  output logic          busy,
  output logic [CW-1:0] drop_cnt
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  logic [0:0] state;
  logic [1:0] ptr;      // round-robin search start
  logic       mode_q;   // mode captured with the in-flight word
  logic [1:0] rr_sel;
  logic [1:0] rr_idx;
  logic       accept;
  logic       dest_ok;

  // Round-robin pick: first enabled channel at or after ptr, modulo 4.
  // NOTE: every signal written in always_comb gets a default first, otherwise
  // a path that skips the assignment infers a latch.
  always_comb begin
    rr_sel = ptr;
    rr_idx = ptr;
    // Scan from the farthest offset down so the nearest enabled channel wins.
    for (int k = 3; k >= 0; k--) begin
      rr_idx = ptr + 2'(k);
      if (chan_en[rr_idx]) rr_sel = rr_idx;
    end
  end

  // Handshake and output decode derived from the current state.
  assign in_ready  = (state == IDLE) && (mode || (chan_en != 4'b0000));
  assign accept    = in_valid && in_ready;
  assign dest_ok   = chan_en[in_dest];
  assign busy      = (state == SEND);
  assign out_valid = (state == SEND) ? (4'b0001 << sel) : 4'b0000;

  // Accept, route, hold until the selected consumer is ready, count drops.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= 2'd0;
      mode_q   <= 1'b0;
      sel      <= 2'd0;
      out_data <= '0;
      drop_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            out_data <= in_data;
            mode_q   <= mode;
            if (!mode) begin
              sel   <= rr_sel;
              state <= SEND;
            end else if (dest_ok) begin
              sel   <= in_dest;
              state <= SEND;
            end else if (drop_cnt != {CW{1'b1}}) begin
              drop_cnt <= drop_cnt + CW'(1);
            end
          end
        end
        SEND: begin
          // Only the selected channel's ready completes the transfer.
          if (out_ready[sel]) begin
            state <= IDLE;
            if (!mode_q) ptr <= sel + 2'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_demux_1x4_sched.sv
// Self-checking bench for demux_1x4_sched: a transaction-level model is
// compared against the DUT on every falling edge, and directed scenarios
// add hand-computed literal expectations.
module tb_demux_1x4_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mode = 1'b0;
  logic [3:0] chan_en = 4'b1111;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic [1:0] in_dest = 2'd0;
  logic [3:0] out_valid;
  logic [3:0] out_ready = 4'b1111;
  logic [7:0] out_data;
  logic [1:0] sel;
  logic       busy;
  logic [7:0] drop_cnt;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  demux_1x4_sched #(.DW(8), .CW(8)) dut (
    .clk(clk), .rst(rst), .mode(mode), .chan_en(chan_en),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_dest(in_dest), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .sel(sel), .busy(busy), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Transaction model: one word in flight or none, plus pointer and drop tally.
  bit         m_pend = 1'b0;
  bit         m_mode = 1'b0;
  int         m_ptr = 0;
  int         m_sel = 0;
  int         m_drops = 0;
  logic [7:0] m_data = 8'h00;

  always @(posedge clk) begin : model
    int pick;
    if (rst) begin
      m_pend  <= 1'b0;
      m_ptr   <= 0;
      m_sel   <= 0;
      m_drops <= 0;
      m_data  <= 8'h00;
    end else if (!m_pend) begin
      if (in_valid && (mode || chan_en != 4'b0000)) begin
        m_data <= in_data;
        m_mode <= mode;
        if (!mode) begin
          pick = -1;
          for (int k = 0; k < 4; k++)
            if (pick < 0 && chan_en[(m_ptr + k) % 4]) pick = (m_ptr + k) % 4;
          m_sel  <= pick;
          m_pend <= 1'b1;
        end else if (chan_en[in_dest]) begin
          m_sel  <= int'(in_dest);
          m_pend <= 1'b1;
        end else begin
          m_drops <= (m_drops < 255) ? m_drops + 1 : 255;
        end
      end
    end else if (out_ready[m_sel]) begin
      m_pend <= 1'b0;
      if (!m_mode) m_ptr <= (m_sel + 1) % 4;
    end
  end

  // Compare process: every falling edge once reset has been applied.
  always @(negedge clk) begin
    if (chk_en) begin
      check("sb.out_valid", 32'(out_valid), m_pend ? 32'(1 << m_sel) : 32'd0);
      check("sb.busy", 32'(busy), 32'(m_pend));
      check("sb.drop_cnt", 32'(drop_cnt), 32'(m_drops));
      check("sb.in_ready", 32'(in_ready), 32'(!m_pend && (mode || chan_en != 4'b0000)));
      if (m_pend) begin
        check("sb.sel", 32'(sel), 32'(m_sel));
        check("sb.out_data", 32'(out_data), 32'(m_data));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one word for one cycle, then look at the outputs mid-cycle.
  task automatic push(input logic [7:0] d, input logic [1:0] dst);
    in_valid = 1'b1;
    in_data  = d;
    in_dest  = dst;
    step();
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  logic [3:0] rr_exp [5];
  logic [3:0] skip_exp [3];
  logic [7:0] skip_dat [3];

  initial begin
    rr_exp   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    skip_exp = '{4'b0010, 4'b1000, 4'b0010};
    skip_dat = '{8'h11, 8'h22, 8'h33};

    // 1. Reset and idle.
    rst = 1'b1;
    step();
    chk_en = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("reset.out_valid", 32'(out_valid), 32'h0);
    check("reset.sel", 32'(sel), 32'h0);
    check("reset.busy", 32'(busy), 32'h0);
    check("reset.drop_cnt", 32'(drop_cnt), 32'h0);
    check("reset.in_ready", 32'(in_ready), 32'h1);
    check("reset.out_data", 32'(out_data), 32'h0);

    // 2. Round-robin across all channels, fifth word wraps.
    mode = 1'b0; chan_en = 4'b1111; out_ready = 4'b1111;
    step();
    for (int i = 0; i < 5; i++) begin
      push(8'hA0 + 8'(i), 2'd0);
      check("rr.out_valid", 32'(out_valid), 32'(rr_exp[i]));
      check("rr.out_data", 32'(out_data), 32'hA0 + 32'(i));
      check("rr.in_ready_send", 32'(in_ready), 32'h0);
      step();
      check("rr.done_busy", 32'(busy), 32'h0);
    end

    // 3. Round-robin skipping disabled channels, then nothing enabled.
    chan_en = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      push(skip_dat[i], 2'd0);
      check("skip.out_valid", 32'(out_valid), 32'(skip_exp[i]));
      check("skip.out_data", 32'(out_data), 32'(skip_dat[i]));
      step();
    end
    chan_en = 4'b0000;
    in_valid = 1'b1; in_data = 8'hEE;
    @(negedge clk);
    check("none.in_ready", 32'(in_ready), 32'h0);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check("none.busy", 32'(busy), 32'h0);
    check("none.out_data_kept", 32'(out_data), 32'h33);

    // 4. Backpressure on channel 0; other ready bits must be ignored.
    chan_en = 4'b0001; out_ready = 4'b0000;
    push(8'h5A, 2'd0);
    for (int i = 0; i < 5; i++) begin
      out_ready = (i < 3) ? 4'b0000 : 4'b1110;
      check("bp.out_valid", 32'(out_valid), 32'h1);
      check("bp.out_data", 32'(out_data), 32'h5A);
      check("bp.in_ready", 32'(in_ready), 32'h0);
      step();
      @(negedge clk);
    end
    check("bp.still_valid", 32'(out_valid), 32'h1);
    out_ready = 4'b0001;
    step();
    check("bp.complete", 32'(out_valid), 32'h0);
    out_ready = 4'b1111;

    // 5. Directed routing, drop, and counter saturation.
    mode = 1'b1; chan_en = 4'b0111;
    push(8'hD2, 2'd2);
    check("dir.dest2", 32'(out_valid), 32'h4);
    step();
    push(8'hD0, 2'd0);
    check("dir.dest0", 32'(out_valid), 32'h1);
    step();
    in_valid = 1'b1; in_data = 8'hD3; in_dest = 2'd3;
    @(negedge clk);
    check("drop.in_ready", 32'(in_ready), 32'h1);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check("drop.out_valid", 32'(out_valid), 32'h0);
    check("drop.count1", 32'(drop_cnt), 32'h1);
    in_valid = 1'b1;
    for (int i = 0; i < 256; i++) step();
    in_valid = 1'b0;
    @(negedge clk);
    check("drop.saturate", 32'(drop_cnt), 32'hFF);

    // 6. Reset while a word is held on channel 2.
    mode = 1'b0; chan_en = 4'b0100; out_ready = 4'b0000;
    push(8'h62, 2'd0);
    check("mid.held", 32'(out_valid), 32'h4);
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("mid.out_valid", 32'(out_valid), 32'h0);
    check("mid.busy", 32'(busy), 32'h0);
    check("mid.drop_cnt", 32'(drop_cnt), 32'h0);
    chan_en = 4'b1111; out_ready = 4'b1111;
    push(8'h70, 2'd0);
    check("mid.ptr_zero", 32'(out_valid), 32'h1);
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/demux_1x4_sched.md
Name: demux_1x4_sched

Overview:
- Scheduler and handshake controller for the 1x4 demultiplexer datapath: accepts words from one upstream source and routes each to one of four downstream channels.
- Two routing modes: round-robin over enabled channels, or directed by a per-word destination field.
- Produces the 2-bit select for the demux and one-hot valid/ready handshakes per channel.
- Sits between a single producer and four consumers.

Parameters:
- DW, 8, width of the data word.
- CW, 8, width of the drop counter (saturating).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- mode  in  1  0 = round-robin, 1 = directed.
- chan_en  in  4  per-channel enable; bit i enables channel i.
- in_valid  in  1  upstream word valid.
- in_ready  out  1  upstream word accepted when in_valid && in_ready.
- in_data  in  DW  upstream word.
- in_dest  in  2  destination channel; used only when mode=1.
- out_valid  out  4  one-hot valid; bit i is for channel i.
- out_ready  in  4  per-channel ready.
- out_data  out  DW  held word, shared by all channels.
- sel  out  2  current demux select (channel being driven).
- busy  out  1  high in SEND.
- drop_cnt  out  CW  count of directed words dropped because the target channel was disabled; saturates at all-ones.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- Reset values:
  - state=IDLE; out_valid=0; out_data=0; sel=0; busy=0; drop_cnt=0.
  - Round-robin pointer ptr=0.
  - rst asserted in SEND discards the held word; no out_valid pulse follows.
- FSM states IDLE and SEND.
- in_ready:
  - 1 only in IDLE, and only when (mode=1) or (chan_en != 0).
  - Always 0 in SEND.
- IDLE, on accept (in_valid && in_ready):
  - Register in_data into out_data.
  - mode=0: sel = first i with chan_en[i]=1, searching ptr, ptr+1, ... mod 4; go to SEND.
  - mode=1, chan_en[in_dest]=1: sel=in_dest; go to SEND.
  - mode=1, chan_en[in_dest]=0: word dropped; drop_cnt += 1 (held at max); stay in IDLE.
- SEND:
  - out_valid = one-hot(sel); busy=1.
  - out_data, sel and out_valid stay stable until out_ready[sel]=1.
  - out_ready bits other than sel are ignored.
  - On out_ready[sel]=1 at a clock edge: transfer completes, out_valid<=0, go to IDLE.
  - If mode=0, ptr <= sel+1 mod 4 (3 wraps to 0). ptr is unchanged by directed transfers.
- Latency and throughput:
  - Word accepted at edge N gives out_valid high from edge N to N+1.
  - With out_ready held high, completion is at edge N+1.
  - Maximum throughput is 1 word per 2 cycles.
- Stable inputs:
  - mode and chan_en are sampled only at accept.
  - Changes during SEND do not affect the in-flight word, even if chan_en[sel] drops to 0.
- out_data holds the last word after completion. Only out_valid qualifies it.
- out_valid is never more than one-hot. out_valid is 0 in IDLE.

Test Plan:
1. Reset and idle: rst=1 for 2 cycles, then 0, with in_valid=0 -> out_valid=0000, sel=00, busy=0, drop_cnt=0, in_ready=1.
2. Round-robin, all enabled: mode=0, chan_en=1111, four words A0,A1,A2,A3, out_ready=1111 -> out_valid sequence 0001,0010,0100,1000 with data A0..A3; a fifth word A4 wraps to 0001.
3. Round-robin skip: chan_en=1010, ptr=0, words 11,22,33 -> channels 1,3,1; chan_en=0000 -> in_ready=0 and no word accepted.
4. Backpressure: mode=0, word 5A to channel 0, out_ready=0000 for 5 cycles, then 0001 -> out_valid=0001 and out_data=5A held stable; in_ready=0 throughout; completion on the edge where out_ready[0]=1.
5. Directed with drop: mode=1, chan_en=0111:
   - Words to dest 2 and dest 0 -> out_valid 0100 then 0001.
   - Word to dest 3 -> in_ready=1, no out_valid, drop_cnt=1.
   - 256 more drops -> drop_cnt saturates at FF.
6. Mid-operation reset: word in SEND on channel 2, rst=1 for one cycle -> next cycle out_valid=0000, busy=0, ptr=0; the next round-robin word goes to channel 0.
